sync_fifo_reader: RTL and testbench

Read-side adapter for the 8-entry scheduling-queue FIFO. It issues read strobes against the FIFO's registered-read port, absorbs the one-cycle read latency in a small skid buffer, and presents the words to a downstream consumer as a valid/ready stream at up to one word per cycle. It sits between the FIFO and the dispatch/ROB-allocate logic, and also keeps a running count of words delivered.

---
 rtl/fifo_pkg.sv | 7 +
 rtl/skid_buf.sv | 56 +++++
 rtl/sync_fifo_reader.sv | 65 ++++++
 tb/tb_sync_fifo_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Constants and types shared between the scheduling-queue FIFO and its read-side adapter.
package fifo_pkg;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 8;

    typedef logic [DATA_W-1:0] fifo_word_t;
endpackage

// File: rtl/skid_buf.sv
// Small power-of-two circular buffer that catches words arriving one cycle after their read strobe.
module skid_buf
    import fifo_pkg::*;
#(
    parameter int W      = fifo_pkg::DATA_W,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [OCC_W-1:0] occ
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !flush;
    assign do_pop    = pop && (occ != '0) && !flush;
    assign head_data = mem[head];

    // Storage is reset too so the head word reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            if (do_push && !do_pop)      occ <= occ + OCC_W'(1);
            else if (do_pop && !do_push) occ <= occ - OCC_W'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side adapter: issues credit-limited reads to a registered-read FIFO and streams the
// words out as valid/ready, counting every word delivered.
module sync_fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W     = fifo_pkg::DATA_W,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              fifo_read,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  rd_count
);

    localparam int OCC_W = $clog2(SKID_DEPTH) + 1;

    logic             pend;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   credit_sum;

    // Handshake: a word transfers on a posedge where out_valid && out_ready; once out_valid is
    // high, out_data holds until that transfer. Transfers during flush are dropped.
    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready && !flush;

    // Counts the buffered words plus the one in flight, net of this cycle's pop, so a read can
    // be issued in the same cycle a slot frees up.
    assign credit_sum = {1'b0, occ} + (OCC_W + 1)'(pend) - (OCC_W + 1)'(pop);
    assign fifo_read  = rst && !fifo_empty && !flush &&
                        (credit_sum < (OCC_W + 1)'(SKID_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend <= 1'b0;
        else      pend <= fifo_read;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rd_count <= '0;
        else if (flush) rd_count <= '0;
        else if (pop)   rd_count <= rd_count + CNT_W'(1);
    end

    skid_buf #(
        .W     (DATA_W),
        .DEPTH (SKID_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (pend),
        .push_data (fifo_rdData),
        .pop       (pop),
        .head_data (out_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: behavioural registered-read FIFO, directed stimulus, and a
// monitor that checks delivered words against an expected queue.
module tb_sync_fifo_reader;

    localparam int DATA_W     = 32;
    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = 16;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              flush     = 1'b0;
    logic              out_ready = 1'b0;
    logic              fifo_read;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdData = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  rd_count;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int push_total = 0;
    int pop_total  = 0;
    int acc_total  = 0;
    int errors     = 0;
    int checks     = 0;

    sync_fifo_reader #(
        .DATA_W     (DATA_W),
        .SKID_DEPTH (SKID_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fifo_read   (fifo_read),
        .fifo_empty  (fifo_empty),
        .fifo_rdData (fifo_rdData),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .rd_count    (rd_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- FIFO model (registered read) ----------------
    assign fifo_empty = (push_total == pop_total);

    always @(posedge clk) begin
        if (fifo_read && !fifo_empty) begin
            fifo_rdData <= fifo_q.pop_front();
            pop_total   <= pop_total + 1;
            acc_total   <= acc_total + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [DATA_W-1:0] w, input bit expect_out);
        fifo_q.push_back(w);
        push_total++;
        if (expect_out) exp_q.push_back(w);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always begin
        @(negedge clk);
        #3;
        if (!rst || flush) begin
            prev_hold = 1'b0;
        end else begin
            check("occ_bound", 32'(dut.u_buf.occ <= 2'(SKID_DEPTH)), 32'd1);
            if (prev_hold) begin
                check("valid_held", 32'(out_valid), 32'd1);
                check("data_stable", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", out_data, $time);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
                prev_hold = 1'b0;
            end else begin
                prev_hold = out_valid;
                prev_data = out_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int first_rd, first_v, last_v, nv, a0, fed;

        // Reset state, with words already waiting in the FIFO.
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        @(negedge clk);
        load(32'h11, 1'b1);
        load(32'h22, 1'b1);
        load(32'h33, 1'b1);
        #1;
        check("rst_gates_read", 32'(fifo_read), 32'd0);

        // Test 1: three words streamed with out_ready held high.
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        first_rd = -1; first_v = -1; last_v = -1; nv = 0;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (fifo_read && first_rd < 0) first_rd = c;
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nv++;
            end
            @(negedge clk);
        end
        check("t1_first_read", 32'(first_rd), 32'd0);
        check("t1_latency", 32'(first_v - first_rd), 32'd2);
        check("t1_valid_cycles", 32'(nv), 32'd3);
        check("t1_back_to_back", 32'(last_v - first_v), 32'd2);
        check("t1_rd_count", 32'(rd_count), 32'd3);

        // Test 2: stalled consumer, then release.
        out_ready = 1'b0;
        a0 = acc_total;
        for (int i = 0; i < 8; i++) load(32'h100 + 32'(i), 1'b1);
        repeat (10) @(negedge clk);
        #3;
        check("t2_reads_issued", 32'(acc_total - a0), 32'd2);
        check("t2_occ", 32'(dut.u_buf.occ), 32'd2);
        check("t2_head_word", out_data, 32'h100);
        check("t2_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        first_v = -1; last_v = -1; nv = 0;
        for (int c = 0; c < 14; c++) begin
            #3;
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nv++;
            end
            @(negedge clk);
        end
        check("t2_words", 32'(nv), 32'd8);
        check("t2_no_gaps", 32'(last_v - first_v), 32'd7);
        check("t2_rd_count", 32'(rd_count), 32'd11);

        // Test 3: out_ready toggling every cycle, FIFO kept fed.
        fed = 0;
        for (int c = 0; c < 300; c++) begin
            out_ready = ~out_ready;
            if (fed < 20 && (push_total - pop_total) < 8) begin
                load(32'h200 + 32'(fed), 1'b1);
                fed++;
            end
            if (fed == 20 && exp_q.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        check("t3_all_fed", 32'(fed), 32'd20);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_rd_count", 32'(rd_count), 32'd31);

        // Test 4: flush while the read of 0xAA is in flight.
        @(negedge clk);
        out_ready = 1'b0;
        load(32'hAA, 1'b0);
        #3;
        check("t4_read_aa", 32'(fifo_read), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        load(32'hBB, 1'b1);
        #3;
        check("t4_flush_blocks_read", 32'(fifo_read), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        #3;
        check("t4_valid_after_flush", 32'(out_valid), 32'd0);
        check("t4_count_after_flush", 32'(rd_count), 32'd0);
        repeat (6) @(negedge clk);
        check("t4_bb_delivered", 32'(exp_q.size()), 32'd0);
        check("t4_rd_count", 32'(rd_count), 32'd1);

        // Test 5: asynchronous reset with a full buffer.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) load(32'h300 + 32'(i), 1'b0);
        repeat (5) @(negedge clk);
        #3;
        check("t5_occ_full", 32'(dut.u_buf.occ), 32'd2);
        #1;
        rst = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_data", out_data, 32'h0);
        check("t5_async_count", 32'(rd_count), 32'd0);
        push_total = push_total - fifo_q.size();
        fifo_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Test 6: FIFO empty throughout.
        out_ready = 1'b1;
        a0 = acc_total;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3;
            check("t6_no_pend", 32'(dut.pend), 32'd0);
            check("t6_no_valid", 32'(out_valid), 32'd0);
        end
        check("t6_no_reads", 32'(acc_total - a0), 32'd0);
        check("t6_rd_count", 32'(rd_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
